// File: rtl/seg7_pkg.sv
// Shared constants and hex decode table for the 7-segment scan display.
// Contents: SEG_OFF (all segments dark), HEX_SEG_TABLE (active-low
// {dp,g,f,e,d,c,b,a} patterns for 0..F), hex_to_seg() lookup function.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n holds the cathode pattern for hex digit n; dp (bit 7) is always off.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to 7-segment cathode decoder (active-low, dp off).
// Ports:
//   nibble - 4-bit hex value to display
//   seg_c  - {dp,g,f,e,d,c,b,a} cathode pattern, combinational
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_c
);

    assign seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment scanner for a 4*DIGITS-bit word.
// Loads land in a staging register and are committed to the displayed
// shadow word only at a frame boundary, so one scan never mixes two words.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero nibble (digit 0 is always shown).
// Ports:
//   SEG_clk      - clock, all logic on posedge
//   SEG_Reset_n  - synchronous active-low reset
//   SEG_Data     - word to display
//   SEG_Load     - one-cycle strobe capturing SEG_Data
//   SEG_Enable   - 1 = scanning, 0 = display dark and scan frozen
//   SEG_Pending  - staged data not yet committed
//   SEG_An       - active-low one-hot anode selects (digit 0 = LSB)
//   SEG_Cathode  - active-low {dp,g,f,e,d,c,b,a}
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned DIGITS  = 8
) (
    input  logic                  SEG_clk,
    input  logic                  SEG_Reset_n,
    input  logic [4*DIGITS-1:0]   SEG_Data,
    input  logic                  SEG_Load,
    input  logic                  SEG_Enable,
    output logic                  SEG_Pending,
    output logic [DIGITS-1:0]     SEG_An,
    output logic [7:0]            SEG_Cathode
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      idx;
    logic [DIGITS-1:0][3:0] staging;
    logic [DIGITS-1:0][3:0] shadow;
    logic                  tick;
    logic                  boundary;
    logic [3:0]            cur_nibble;
    logic [7:0]            cur_seg_c;
    logic                  blank;

    assign tick       = SEG_Enable && (count == CNT_MAX);
    assign boundary   = tick && (idx == IDX_MAX);
    assign cur_nibble = shadow[idx];

    seg7_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg_c  (cur_seg_c)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // blank_mask[i] is set when nibbles i..DIGITS-1 are all zero (never for digit 0).
    logic [DIGITS-1:0] blank_mask;
    logic              seen_nonzero;

    always_comb begin
        blank_mask   = '0;
        seen_nonzero = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            seen_nonzero  = seen_nonzero | (shadow[i] != 4'h0);
            blank_mask[i] = !seen_nonzero;
        end
    end

    assign blank = blank_mask[idx];
`else
    assign blank = 1'b0;
`endif

    // Prescaler and digit index; both freeze while disabled.
    always_ff @(posedge SEG_clk) begin
        if (!SEG_Reset_n) begin
            count <= '0;
            idx   <= '0;
        end else if (SEG_Enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Staging/shadow handshake; a load on the boundary or while dark bypasses staging.
    always_ff @(posedge SEG_clk) begin
        if (!SEG_Reset_n) begin
            staging     <= '0;
            shadow      <= '0;
            SEG_Pending <= 1'b0;
        end else if (!SEG_Enable) begin
            if (SEG_Load) begin
                staging     <= SEG_Data;
                shadow      <= SEG_Data;
                SEG_Pending <= 1'b0;
            end
        end else if (boundary) begin
            if (SEG_Load) begin
                staging <= SEG_Data;
                shadow  <= SEG_Data;
            end else if (SEG_Pending) begin
                shadow  <= staging;
            end
            SEG_Pending <= 1'b0;
        end else if (SEG_Load) begin
            staging     <= SEG_Data;
            SEG_Pending <= 1'b1;
        end
    end

    // Registered anode/cathode drive from the current index and shadow word.
    always_ff @(posedge SEG_clk) begin
        if (!SEG_Reset_n) begin
            SEG_An      <= '1;
            SEG_Cathode <= SEG_OFF;
        end else begin
            SEG_An      <= SEG_Enable ? ~(DIGITS'(1) << idx) : '1;
            SEG_Cathode <= (SEG_Enable && !blank) ? cur_seg_c : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display with CLK_DIV = 4, DIGITS = 8.
// Stimulus pushes cycle-stamped expectations; a negedge monitor compares them.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data;
    logic        load;
    logic        enable;
    logic        pending;
    logic [7:0]  an;
    logic [7:0]  cathode;

    seg7_scan_display #(.CLK_DIV(4), .DIGITS(8)) dut (
        .SEG_clk     (clk),
        .SEG_Reset_n (reset_n),
        .SEG_Data    (data),
        .SEG_Load    (load),
        .SEG_Enable  (enable),
        .SEG_Pending (pending),
        .SEG_An      (an),
        .SEG_Cathode (cathode)
    );

    always #5 clk = ~clk;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    // kind 0: anode/cathode check, kind 1: pending check
    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] an;
        logic [7:0] cat;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sb[i].kind == 0) begin
                    if (an !== sb[i].an || cathode !== sb[i].cat) begin
                        errors++;
                        $display("FAIL an_cat cyc=%0d got an=%h cat=%h want an=%h cat=%h",
                                 cyc, an, cathode, sb[i].an, sb[i].cat);
                    end
                end else begin
                    if (pending !== sb[i].pend) begin
                        errors++;
                        $display("FAIL pending cyc=%0d got %b want %b", cyc, pending, sb[i].pend);
                    end
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_out(input int c, input logic [7:0] a, input logic [7:0] k);
        exp_t e;
        e.cyc = c; e.kind = 0; e.an = a; e.cat = k; e.pend = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_pend(input int c, input logic p);
        exp_t e;
        e.cyc = c; e.kind = 1; e.an = 8'h00; e.cat = 8'h00; e.pend = p;
        sb.push_back(e);
    endtask

    task automatic exp_slot(input int start, input int len, input logic [7:0] a, input logic [7:0] k);
        for (int j = 0; j < len; j++) exp_out(start + j, a, k);
    endtask

    // cats[d] is the hand-decoded cathode for digit d; each digit holds 4 cycles.
    task automatic exp_frame(input int start, input logic [7:0][7:0] cats);
        logic [7:0][7:0] ans;
        ans = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        for (int d = 0; d < 8; d++) exp_slot(start + 4 * d, 4, ans[d], cats[d]);
    endtask

    // Return just after posedge p-1 so the next drive is sampled at posedge p.
    task automatic go(input int p);
        while (cyc < p - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        load    = 1'b0;
        data    = 32'h0;

        // Reset held for posedges 1..3, frame 0 shows the zero word.
        for (int c = 1; c <= 3; c++) begin
            exp_out(c, 8'hFF, 8'hFF);
            exp_pend(c, 1'b0);
        end
        exp_frame(4, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 8'hC0});
        exp_pend(16, 1'b0);
        go(4);
        reset_n = 1'b1;

        // Load at index 3 of frame 0; commits at boundary posedge 35.
        go(17);
        load = 1'b1; data = 32'h0123_4567;
        exp_pend(17, 1'b1);
        exp_pend(34, 1'b1);
        exp_pend(35, 1'b0);
        exp_frame(36, {LZ, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8});
        go(18);
        load = 1'b0;

        // Two loads in frame 1; the last one wins in frame 2.
        go(40);
        load = 1'b1; data = 32'hAAAA_AAAA;
        exp_pend(41, 1'b1);
        go(41);
        load = 1'b0;
        go(50);
        load = 1'b1; data = 32'h5555_5555;
        exp_pend(50, 1'b1);
        exp_pend(66, 1'b1);
        exp_pend(67, 1'b0);
        exp_frame(68, {8{8'h92}});
        go(51);
        load = 1'b0;

        // Load on the boundary cycle (posedge 99) commits at once.
        go(99);
        load = 1'b1; data = 32'hFFFF_FFFF;
        exp_pend(99, 1'b0);
        exp_pend(100, 1'b0);
        exp_slot(100, 4, 8'hFE, 8'h8E);
        exp_slot(104, 4, 8'hFD, 8'h8E);
        exp_slot(108, 4, 8'hFB, 8'h8E);
        exp_slot(112, 4, 8'hF7, 8'h8E);
        exp_slot(116, 4, 8'hEF, 8'h8E);
        exp_slot(120, 2, 8'hDF, 8'h8E);
        exp_slot(122, 10, 8'hFF, 8'hFF);
        go(100);
        load = 1'b0;

        // Disable mid digit 5 for 10 cycles; load while dark goes straight to shadow.
        go(122);
        enable = 1'b0;
        go(125);
        load = 1'b1; data = 32'h0000_00A5;
        exp_pend(125, 1'b0);
        exp_pend(126, 1'b0);
        exp_slot(132, 2, 8'hDF, LZ);
        exp_slot(134, 4, 8'hBF, LZ);
        exp_slot(138, 4, 8'h7F, LZ);
        exp_frame(142, {LZ, LZ, LZ, LZ, LZ, LZ, 8'h88, 8'h92});
        go(126);
        load = 1'b0;
        go(132);
        enable = 1'b1;

        // Reset mid-frame overrides a simultaneous load.
        go(176);
        reset_n = 1'b0; load = 1'b1; data = 32'hFFFF_FFFF;
        exp_out(176, 8'hFF, 8'hFF);
        exp_out(177, 8'hFF, 8'hFF);
        exp_pend(177, 1'b0);
        go(177);
        load = 1'b0;
        go(178);
        reset_n = 1'b1;
        exp_out(178, 8'hFE, 8'hC0);
        exp_pend(178, 1'b0);

        go(181);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover expectations got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
